// File: rtl/alu_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_chk_pkg
// Description : Shared opcode map, checker state encoding and default width
//               for the Y86 ALU result checker.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_chk_pkg;

    localparam int DEFAULT_WIDTH = 64;

    // Y86 OPq ifun order; the ALU under test decodes the same values
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : alu_ref_model
// Description : Combinational expected-result function for the Y86 ALU.
//               Results wrap modulo 2^WIDTH; flags are not produced.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ref_model
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_exp
);

    // Decode the opcode and compute the expected ALU result
    always_comb begin
        o_exp = '0;
        unique case (i_op)
            ALU_ADD: o_exp = i_a + i_b;
            ALU_SUB: o_exp = i_a - i_b;
            ALU_AND: o_exp = i_a & i_b;
            ALU_XOR: o_exp = i_a ^ i_b;
            default: o_exp = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_checker
// Description : Scores a handshaked stream of ALU operand/opcode/result
//               tuples against a reference model. Two-stage pipeline
//               (expect, then compare), pass/fail counters and first-mismatch
//               capture. Runs of NUM_VECTORS tuples are started by 'start'.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp,
    output logic [WIDTH-1:0] first_fail_got
);

    localparam logic [CNT_W-1:0] c_NUM_VEC  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    chk_state_t       r_state;
    chk_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             w_xfer;
    logic             w_last_xfer;
    logic             w_start_ok;
    logic [WIDTH-1:0] w_exp;

    logic             r_s1_valid;
    logic [CNT_W-1:0] r_s1_idx;
    logic [WIDTH-1:0] r_s1_exp;
    logic [WIDTH-1:0] r_s1_got;
    logic             w_mismatch;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .i_op  (in_op),
        .i_a   (in_a),
        .i_b   (in_b),
        .o_exp (w_exp)
    );

    assign in_ready    = (r_state == RUN) && (r_acc_cnt < c_NUM_VEC);
    assign w_xfer      = in_valid && in_ready;
    assign w_last_xfer = w_xfer && (r_acc_cnt == c_LAST_IDX);
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch  = (r_s1_exp != r_s1_got);
    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN only ever holds the final vector in stage 1,
    // which is scored on the edge that leaves DRAIN
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok)  w_state_nxt = RUN;
            RUN:     if (w_last_xfer) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    if (w_start_ok)  w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accepted-tuple counter, also the index of the next vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
        end else if (w_start_ok) begin
            r_acc_cnt <= '0;
        end else if (w_xfer) begin
            r_acc_cnt <= r_acc_cnt + c_ONE;
        end
    end

    // Stage 1: capture index, expected and observed result on each transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_exp   <= '0;
            r_s1_got   <= '0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_idx <= r_acc_cnt;
                r_s1_exp <= w_exp;
                r_s1_got <= in_out;
            end
        end
    end

    // Stage 2: compare, count, and latch the first mismatch of the run
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_ok) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (r_s1_valid) begin
            if (w_mismatch) begin
                fail_cnt <= fail_cnt + c_ONE;
                err      <= 1'b1;
                if (!err) begin
                    first_fail_idx <= r_s1_idx;
                    first_fail_exp <= r_s1_exp;
                    first_fail_got <= r_s1_got;
                end
            end else begin
                pass_cnt <= pass_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire
